rv32i_dmem_arbiter: RTL

RV32I_DMEM_ARBITER -- requirements
Module: rv32i_dmem_arbiter

---
 rtl/rv32i_dmem_pkg.sv | 13 +
 rtl/rv32i_rr_arbiter2.sv | 21 ++
 rtl/rv32i_dmem_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/rv32i_dmem_pkg.sv
// Shared definitions for the RV32I data-memory arbiter: FSM encodings and port indices.
package rv32i_dmem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_EXT  = 1'b1;

endpackage

// File: rtl/rv32i_rr_arbiter2.sv
// Two-way round-robin pick: on a tie, the port that was not granted last wins.
module rv32i_rr_arbiter2
    import rv32i_dmem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant,
    output logic       valid
);

    always_comb begin
        valid = |req;
        grant = PORT_CORE;
        if (req == 2'b11) begin
            grant = ~last_grant;
        end else if (req[1]) begin
            grant = PORT_EXT;
        end
    end

endmodule

// File: rtl/rv32i_dmem_arbiter.sv
// Arbitrates the core LSU (port 0) and DMA/debug (port 1) onto one data-memory port,
// with a per-access timeout that returns an error response.
module rv32i_dmem_arbiter
    import rv32i_dmem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    input  logic [3:0]  mask0,
    input  logic [3:0]  mask1,
    output logic        ack0,
    output logic        ack1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_mask,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] LAST_CYCLE = CW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          last_grant;
    logic          gnt_port;
    logic          pick;
    logic          pick_valid;

    logic          sel_we;
    logic [31:0]   sel_addr;
    logic [31:0]   sel_wdata;
    logic [3:0]    sel_mask;

    rv32i_rr_arbiter2 u_rr (
        .req        ({req1, req0}),
        .last_grant (last_grant),
        .grant      (pick),
        .valid      (pick_valid)
    );

    assign sel_we    = (pick == PORT_EXT) ? we1    : we0;
    assign sel_addr  = (pick == PORT_EXT) ? addr1  : addr0;
    assign sel_wdata = (pick == PORT_EXT) ? wdata1 : wdata0;
    assign sel_mask  = (pick == PORT_EXT) ? mask1  : mask0;

    // Command fields are captured once at grant; requester changes after that are invisible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= PORT_EXT;
            gnt_port   <= PORT_CORE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_mask   <= '0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            err0       <= 1'b0;
            err1       <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        gnt_port  <= pick;
                        mem_req   <= 1'b1;
                        mem_we    <= sel_we;
                        mem_addr  <= sel_addr & 32'hFFFF_FFFC;
                        mem_wdata <= sel_wdata;
                        mem_mask  <= sel_we ? sel_mask : 4'b1111;
                        cnt       <= '0;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        ack0    <= (gnt_port == PORT_CORE);
                        ack1    <= (gnt_port == PORT_EXT);
                        rdata0  <= (gnt_port == PORT_CORE && !mem_we) ? mem_rdata : 32'h0;
                        rdata1  <= (gnt_port == PORT_EXT  && !mem_we) ? mem_rdata : 32'h0;
                        state   <= RESP;
                    end else if (cnt == LAST_CYCLE) begin
                        mem_req <= 1'b0;
                        ack0    <= (gnt_port == PORT_CORE);
                        ack1    <= (gnt_port == PORT_EXT);
                        err0    <= (gnt_port == PORT_CORE);
                        err1    <= (gnt_port == PORT_EXT);
                        rdata0  <= 32'h0;
                        rdata1  <= 32'h0;
                        state   <= RESP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RESP: begin
                    ack0       <= 1'b0;
                    ack1       <= 1'b0;
                    err0       <= 1'b0;
                    err1       <= 1'b0;
                    rdata0     <= 32'h0;
                    rdata1     <= 32'h0;
                    last_grant <= gnt_port;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
